// File: rtl/aes_run_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_run_sequencer_if
// Description : Bundles the UART-controller slot-bank port and the AES-core
//               port of the run sequencer.
//               slave  - used by aes_run_sequencer
//               master - used by whatever drives the sequencer (UART side
//                        plus AES core side)
// Signals     : swrst, run, extin_en/addr/data     host -> sequencer
//               extout_addr / extout_data          registered slot read
//               core_key, core_din, core_start     sequencer -> core
//               core_dout, core_done               core -> sequencer
//               core_abort, trigger, busy          sequencer status/control
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_run_sequencer_if #(
    parameter int DATA_W = 128
);
    logic              swrst;
    logic              run;
    logic              extin_en;
    logic [7:0]        extin_addr;
    logic [DATA_W-1:0] extin_data;
    logic [7:0]        extout_addr;
    logic [DATA_W-1:0] extout_data;
    logic [DATA_W-1:0] core_key;
    logic [DATA_W-1:0] core_din;
    logic              core_start;
    logic [DATA_W-1:0] core_dout;
    logic              core_done;
    logic              core_abort;
    logic              trigger;
    logic              busy;

    modport slave (
        input  swrst,
        input  run,
        input  extin_en,
        input  extin_addr,
        input  extin_data,
        input  extout_addr,
        output extout_data,
        output core_key,
        output core_din,
        output core_start,
        input  core_dout,
        input  core_done,
        output core_abort,
        output trigger,
        output busy
    );

    modport master (
        output swrst,
        output run,
        output extin_en,
        output extin_addr,
        output extin_data,
        output extout_addr,
        input  extout_data,
        input  core_key,
        input  core_din,
        input  core_start,
        output core_dout,
        output core_done,
        input  core_abort,
        input  trigger,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/aes_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aes_run_sequencer
// Description : Host-side run controller between the UART command controller
//               and an AES core. Holds KEY/PT/CT/CFG/STATUS slots, sequences
//               N chained encryptions per run pulse, drives the scope trigger,
//               aborts the core on timeout and keeps the last ciphertext.
// Parameters  : DATA_W      - slot / AES block width (multiple of 8, >= 16)
//               TIMEOUT_CYC - max core_start-to-core_done cycles (>= 2)
// Ports       : clk, rst    - clock, synchronous active-high reset
//               bus         - aes_run_sequencer_if.slave (host + core ports)
// Slot map    : 0 KEY (rw) 1 PT (rw) 2 CT (ro) 3 CFG (rw, [7:0] ITER)
//               4 STATUS (ro: [0] busy [1] timeout [2] wr_drop [15:8] iters)
// Revision    : 1.0 - initial release
// ============================================================================
module aes_run_sequencer #(
    parameter int DATA_W      = 128,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    aes_run_sequencer_if.slave bus
);

    localparam logic [7:0] C_ADDR_KEY    = 8'd0;
    localparam logic [7:0] C_ADDR_PT     = 8'd1;
    localparam logic [7:0] C_ADDR_CT     = 8'd2;
    localparam logic [7:0] C_ADDR_CFG    = 8'd3;
    localparam logic [7:0] C_ADDR_STATUS = 8'd4;

    localparam int                 C_CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [C_CNT_W-1:0] C_TMO_LAST = C_CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_STORE = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Slot bank
    logic [DATA_W-1:0]  r_key;
    logic [DATA_W-1:0]  r_pt;
    logic [DATA_W-1:0]  r_ct;
    logic [DATA_W-1:0]  r_cfg;

    // Run bookkeeping
    logic               r_timeout;
    logic               r_wr_drop;
    logic [7:0]         r_iter_cnt;
    logic [7:0]         r_iter_tgt;
    logic [C_CNT_W-1:0] r_tmo_cnt;
    logic [DATA_W-1:0]  r_dout_cap;

    // Registered outputs
    logic [DATA_W-1:0]  r_core_key;
    logic [DATA_W-1:0]  r_core_din;
    logic               r_abort;
    logic [DATA_W-1:0]  r_extout;

    // Combinational control
    logic               w_busy;
    logic               w_core_start;
    logic               w_trigger;
    logic               w_run_accept;
    logic               w_timeout_hit;
    logic               w_iter_more;
    logic               w_writable;
    logic               w_wr_en;
    logic [7:0]         w_cfg_iter;
    logic [DATA_W-1:0]  w_rd_data;

    assign w_busy = (r_state != S_IDLE);

    // Only KEY, PT and CFG accept host writes; everything else is dropped.
    assign w_writable = (bus.extin_addr == C_ADDR_KEY) ||
                        (bus.extin_addr == C_ADDR_PT)  ||
                        (bus.extin_addr == C_ADDR_CFG);

    // swrst suppresses writes so that KEY/PT/CFG survive it untouched.
    assign w_wr_en = bus.extin_en && w_writable && !w_busy && !bus.swrst;

    // ITER as it will be after this edge: a CFG write coinciding with run
    // must be the value the new run uses.
    assign w_cfg_iter = (w_wr_en && (bus.extin_addr == C_ADDR_CFG)) ?
                        bus.extin_data[7:0] : r_cfg[7:0];

    // Another pass is needed when the count after this STORE is still short.
    assign w_iter_more = (({1'b0, r_iter_cnt} + 9'd1) < {1'b0, r_iter_tgt});

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_core_start  = 1'b0;
        w_trigger     = 1'b0;
        w_run_accept  = 1'b0;
        w_timeout_hit = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.run) begin
                    w_state_next = S_LOAD;
                    w_run_accept = 1'b1;
                end
            end
            S_LOAD: begin
                w_state_next = S_START;
            end
            S_START: begin
                w_core_start = 1'b1;
                w_trigger    = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                // Trigger stays high through the core_done cycle itself.
                w_trigger = 1'b1;
                if (bus.core_done) begin
                    w_state_next = S_STORE;
                end else if (r_tmo_cnt == C_TMO_LAST) begin
                    w_state_next  = S_IDLE;
                    w_timeout_hit = 1'b1;
                end
            end
            S_STORE: begin
                w_state_next = w_iter_more ? S_LOAD : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Soft reset overrides any transition taken this cycle.
        if (bus.swrst) begin
            w_state_next  = S_IDLE;
            w_run_accept  = 1'b0;
            w_timeout_hit = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Host-writable slots (KEY, PT, CFG): cleared by rst only
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key <= '0;
            r_pt  <= '0;
            r_cfg <= '0;
        end else if (w_wr_en) begin
            case (bus.extin_addr)
                C_ADDR_KEY: r_key <= bus.extin_data;
                C_ADDR_PT:  r_pt  <= bus.extin_data;
                C_ADDR_CFG: r_cfg <= bus.extin_data;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Run datapath: core operands, timeout counter, CT and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ct       <= '0;
            r_timeout  <= 1'b0;
            r_wr_drop  <= 1'b0;
            r_iter_cnt <= '0;
            r_iter_tgt <= '0;
            r_tmo_cnt  <= '0;
            r_dout_cap <= '0;
            r_core_key <= '0;
            r_core_din <= '0;
            r_abort    <= 1'b0;
        end else begin
            // Pulse lasts exactly one cycle after the swrst / timeout edge.
            r_abort <= bus.swrst || w_timeout_hit;

            if (bus.swrst) begin
                r_ct       <= '0;
                r_timeout  <= 1'b0;
                r_wr_drop  <= 1'b0;
                r_iter_cnt <= '0;
                r_dout_cap <= '0;
            end else begin
                if (bus.extin_en && w_writable && w_busy) begin
                    r_wr_drop <= 1'b1;
                end

                if (w_run_accept) begin
                    r_timeout  <= 1'b0;
                    r_wr_drop  <= 1'b0;
                    r_iter_cnt <= '0;
                    r_iter_tgt <= (w_cfg_iter == 8'd0) ? 8'd1 : w_cfg_iter;
                end

                if (w_timeout_hit) begin
                    r_timeout <= 1'b1;
                end

                case (r_state)
                    S_LOAD: begin
                        // Later passes chain on the previous ciphertext.
                        r_core_key <= r_key;
                        r_core_din <= (r_iter_cnt == 8'd0) ? r_pt : r_ct;
                    end
                    S_START: begin
                        r_tmo_cnt <= '0;
                    end
                    S_WAIT: begin
                        r_tmo_cnt <= r_tmo_cnt + C_CNT_W'(1);
                        if (bus.core_done) begin
                            r_dout_cap <= bus.core_dout;
                        end
                    end
                    S_STORE: begin
                        r_ct <= r_dout_cap;
                        if (r_iter_cnt != 8'hFF) begin
                            r_iter_cnt <= r_iter_cnt + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Slot read mux and registered read port
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_data = '0;
        case (bus.extout_addr)
            C_ADDR_KEY: w_rd_data = r_key;
            C_ADDR_PT:  w_rd_data = r_pt;
            C_ADDR_CT:  w_rd_data = r_ct;
            C_ADDR_CFG: w_rd_data = r_cfg;
            C_ADDR_STATUS: begin
                w_rd_data[0]    = w_busy;
                w_rd_data[1]    = r_timeout;
                w_rd_data[2]    = r_wr_drop;
                w_rd_data[15:8] = r_iter_cnt;
            end
            default: w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_extout <= '0;
        end else begin
            r_extout <= w_rd_data;
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign bus.extout_data = r_extout;
    assign bus.core_key    = r_core_key;
    assign bus.core_din    = r_core_din;
    assign bus.core_start  = w_core_start;
    assign bus.core_abort  = r_abort;
    assign bus.trigger     = w_trigger;
    assign bus.busy        = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_aes_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_run_sequencer
// Description : Self-checking bench for aes_run_sequencer. A behavioural AES
//               core model answers core_start after a programmable latency
//               (or never). Every run pushes the expected core operands to a
//               scoreboard queue that is popped on each core_start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_run_sequencer;

    localparam int DATA_W      = 128;
    localparam int TIMEOUT_CYC = 32;

    localparam logic [127:0] C_KEY    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_CT     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_PT_ALT = 128'hdeadbeef0badf00dcafef00d12345678;

    typedef struct packed {
        logic [127:0] key;
        logic [127:0] din;
    } core_req_t;

    core_req_t    sb_q[$];

    logic         clk = 1'b0;
    logic         rst;
    int           n_tests     = 0;
    int           n_fail      = 0;
    int           cyc         = 0;
    int           n_starts    = 0;
    int           n_aborts    = 0;
    int           trig_cycles = 0;
    int           start_cyc   = 0;
    int           abort_cyc   = 0;
    int           core_lat    = 10;
    bit           core_hang   = 1'b0;
    int           core_cnt    = 0;
    logic [127:0] lat_key;
    logic [127:0] lat_din;

    aes_run_sequencer_if #(.DATA_W(DATA_W)) bus ();

    aes_run_sequencer #(
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Stand-in for AES: the FIPS-197 C.1 pair maps to its real ciphertext,
    // anything else goes through a cheap invertible mix.
    function automatic logic [127:0] model_core(input logic [127:0] k, input logic [127:0] d);
        if (k == C_KEY && d == C_PT) return C_CT;
        return {d[119:0], d[127:120]} ^ k ^ 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
    endfunction

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pushes the operand chain a run of n passes should present to the core.
    task automatic push_chain(input logic [127:0] k, input logic [127:0] d0, input int n,
                              output logic [127:0] ct);
        core_req_t    r;
        logic [127:0] d;
        d = d0;
        for (int i = 0; i < n; i++) begin
            r.key = k;
            r.din = d;
            sb_q.push_back(r);
            d = model_core(k, d);
        end
        ct = d;
    endtask

    task automatic write_slot(input logic [7:0] a, input logic [127:0] d);
        @(posedge clk); #1;
        bus.extin_en   = 1'b1;
        bus.extin_addr = a;
        bus.extin_data = d;
        @(posedge clk); #1;
        bus.extin_en   = 1'b0;
    endtask

    task automatic read_slot(input logic [7:0] a, output logic [127:0] d);
        @(posedge clk); #1;
        bus.extout_addr = a;
        @(posedge clk);
        @(negedge clk);
        d = bus.extout_data;
    endtask

    // Returns cycles from the run cycle (inclusive) to the first idle cycle.
    task automatic do_run(input int max_cyc, output int cycles);
        @(posedge clk); #1;
        bus.run = 1'b1;
        @(posedge clk); #1;
        bus.run = 1'b0;
        cycles = 1;
        forever begin
            @(negedge clk);
            if (!bus.busy) break;
            cycles++;
            if (cycles > max_cyc) begin
                check_val("run_bound", 128'(cycles), 128'(max_cyc));
                break;
            end
        end
    endtask

    // Core model and output monitor
    initial begin
        core_req_t e;
        bus.core_done = 1'b0;
        bus.core_dout = '0;
        forever begin
            @(negedge clk);
            bus.core_done = 1'b0;
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    bus.core_done = 1'b1;
                    bus.core_dout = model_core(lat_key, lat_din);
                end
            end
            if (bus.core_start) begin
                n_starts++;
                start_cyc = cyc;
                check_val("sb_nonempty", 128'(sb_q.size() != 0), 128'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check_val("core_din", bus.core_din, e.din);
                    check_val("core_key", bus.core_key, e.key);
                end
                lat_key = bus.core_key;
                lat_din = bus.core_din;
                if (!core_hang) core_cnt = core_lat;
            end
            if (bus.trigger) trig_cycles++;
            if (bus.core_abort) begin
                n_aborts++;
                abort_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] rd;
        logic [127:0] exp_ct;
        int           cycles;
        int           s0;
        int           t0;
        int           a0;

        rst             = 1'b1;
        bus.swrst       = 1'b0;
        bus.run         = 1'b0;
        bus.extin_en    = 1'b0;
        bus.extin_addr  = '0;
        bus.extin_data  = '0;
        bus.extout_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_val("rst_busy", 128'(bus.busy), 128'd0);
        check_val("rst_extout", bus.extout_data, 128'd0);
        check_val("rst_abort", 128'(bus.core_abort), 128'd0);
        check_val("rst_trigger", 128'(bus.trigger), 128'd0);
        check_val("rst_core_key", bus.core_key, 128'd0);
        read_slot(8'd4, rd);
        check_val("rst_status", rd, 128'd0);

        // Single FIPS-197 encryption
        write_slot(8'd0, C_KEY);
        write_slot(8'd1, C_PT);
        write_slot(8'd3, 128'd1);
        read_slot(8'd0, rd);  check_val("rd_key", rd, C_KEY);
        read_slot(8'd1, rd);  check_val("rd_pt", rd, C_PT);
        read_slot(8'd3, rd);  check_val("rd_cfg", rd, 128'd1);
        core_lat = 10;
        push_chain(C_KEY, C_PT, 1, exp_ct);
        s0 = n_starts;
        t0 = trig_cycles;
        do_run(200, cycles);
        check_val("busy_len_n1", 128'(cycles), 128'(1 * (10 + 3) + 1));
        check_val("starts_n1", 128'(n_starts - s0), 128'd1);
        check_val("trigger_len", 128'(trig_cycles - t0), 128'd11);
        read_slot(8'd2, rd);  check_val("ct_fips", rd, C_CT);
        read_slot(8'd4, rd);  check_val("status_n1", rd, 128'h100);

        // PT write while busy is dropped and flagged
        push_chain(C_KEY, C_PT, 1, exp_ct);
        fork
            do_run(200, cycles);
            begin
                repeat (5) @(negedge clk);
                write_slot(8'd1, C_PT_ALT);
            end
        join
        read_slot(8'd1, rd);  check_val("pt_kept", rd, C_PT);
        read_slot(8'd4, rd);  check_val("status_wr_drop", rd, 128'h104);

        // Next accepted run clears wr_drop
        push_chain(C_KEY, C_PT, 1, exp_ct);
        do_run(200, cycles);
        read_slot(8'd4, rd);  check_val("status_drop_clr", rd, 128'h100);

        // Three chained passes, with a stray run pulse while busy
        write_slot(8'd3, 128'd3);
        core_lat = 5;
        push_chain(C_KEY, C_PT, 3, exp_ct);
        s0 = n_starts;
        fork
            do_run(400, cycles);
            begin
                repeat (6) @(negedge clk);
                bus.run = 1'b1;
                @(negedge clk);
                bus.run = 1'b0;
            end
        join
        check_val("busy_len_n3", 128'(cycles), 128'(3 * (5 + 3) + 1));
        check_val("starts_n3", 128'(n_starts - s0), 128'd3);
        read_slot(8'd2, rd);  check_val("ct_chain3", rd, exp_ct);
        read_slot(8'd4, rd);  check_val("status_n3", rd, 128'h300);

        // ITER = 0 behaves as one pass
        write_slot(8'd3, 128'd0);
        core_lat = 7;
        push_chain(C_KEY, C_PT, 1, exp_ct);
        s0 = n_starts;
        do_run(200, cycles);
        check_val("busy_len_it0", 128'(cycles), 128'(7 + 3 + 1));
        check_val("starts_it0", 128'(n_starts - s0), 128'd1);
        read_slot(8'd2, rd);  check_val("ct_it0", rd, C_CT);
        read_slot(8'd4, rd);  check_val("status_it0", rd, 128'h100);

        // Core never answers: timeout path
        write_slot(8'd3, 128'd1);
        core_hang = 1'b1;
        push_chain(C_KEY, C_PT, 1, exp_ct);
        a0 = n_aborts;
        do_run(300, cycles);
        check_val("busy_len_tmo", 128'(cycles), 128'(TIMEOUT_CYC + 3));
        repeat (3) @(negedge clk);
        check_val("aborts_tmo", 128'(n_aborts - a0), 128'd1);
        check_val("abort_delay", 128'(abort_cyc - start_cyc), 128'(TIMEOUT_CYC + 1));
        check_val("busy_tmo", 128'(bus.busy), 128'd0);
        read_slot(8'd4, rd);  check_val("status_tmo", rd, 128'h2);
        read_slot(8'd2, rd);  check_val("ct_tmo_kept", rd, C_CT);
        core_hang = 1'b0;

        // Soft reset in the middle of WAIT
        core_lat = 40;
        push_chain(C_KEY, C_PT, 1, exp_ct);
        a0 = n_aborts;
        fork
            do_run(300, cycles);
            begin
                repeat (8) @(negedge clk);
                bus.swrst = 1'b1;
                @(negedge clk);
                check_val("swrst_busy", 128'(bus.busy), 128'd0);
                check_val("swrst_abort", 128'(bus.core_abort), 128'd1);
                check_val("swrst_trigger", 128'(bus.trigger), 128'd0);
                bus.swrst = 1'b0;
            end
        join
        read_slot(8'd0, rd);  check_val("swrst_key", rd, C_KEY);
        read_slot(8'd1, rd);  check_val("swrst_pt", rd, C_PT);
        read_slot(8'd3, rd);  check_val("swrst_cfg", rd, 128'd1);
        read_slot(8'd2, rd);  check_val("swrst_ct", rd, 128'd0);
        read_slot(8'd4, rd);  check_val("swrst_status", rd, 128'd0);
        // The late core_done lands outside WAIT and must change nothing.
        repeat (50) @(negedge clk);
        check_val("swrst_aborts", 128'(n_aborts - a0), 128'd1);
        read_slot(8'd2, rd);  check_val("late_done_ct", rd, 128'd0);
        read_slot(8'd4, rd);  check_val("late_done_status", rd, 128'd0);

        // Unmapped and read-only addresses
        write_slot(8'd7, C_PT_ALT);
        read_slot(8'd7, rd);  check_val("rd_addr7", rd, 128'd0);
        write_slot(8'd2, C_PT_ALT);
        read_slot(8'd2, rd);  check_val("ct_ro", rd, 128'd0);

        // rst and swrst together: no abort pulse, slots cleared
        @(posedge clk); #1;
        rst       = 1'b1;
        bus.swrst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.swrst = 1'b0;
        @(negedge clk);
        check_val("rst_swrst_abort", 128'(bus.core_abort), 128'd0);
        read_slot(8'd0, rd);  check_val("rst2_key", rd, 128'd0);

        check_val("sb_empty", 128'(sb_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
